// File: rtl/datapath_ctrl_fsm.sv
// datapath_ctrl_fsm: multi-cycle controller for a CR16A-style regfile/ALU datapath.
// It accepts one instruction at a time, decodes R-type and I-type formats, and
// sequences the instruction through DECODE, EXEC and WRITEBACK. It also shares
// the single regfile write port with external inData loads, which take priority.
// Optional feature macro: PSR_FLAGS_EN (load psr from flags_in at the end of EXEC).
module datapath_ctrl_fsm #(
    parameter int         DATA_W   = 16,
    parameter int         NUM_REGS = 16,
    parameter logic [3:0] CMP_OP   = 4'b1011
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [15:0]         instr,
    output logic                instr_ready,
    input  logic                ext_valid,
    input  logic [3:0]          ext_addr,
    output logic                ext_ready,
    output logic [3:0]          raddrA,
    output logic [3:0]          raddrB,
    output logic [NUM_REGS-1:0] reg_en,
    output logic [1:0]          wb_sel,
    output logic [1:0]          imm_sel,
    output logic [DATA_W-1:0]   imm,
    output logic [3:0]          alu_op,
    input  logic [4:0]          flags_in,
    output logic [4:0]          psr,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DECODE,
        S_EXEC,
        S_WRITEBACK
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_instr_q;
    logic [3:0]  r_ext_addr_q;

    logic                w_rtype;
    logic                w_nop;
    logic                w_no_wb;
    logic [3:0]          w_alu_op;
    logic [3:0]          w_rsrc;
    logic [3:0]          w_rdest;
    logic [DATA_W-1:0]   w_imm_ext;
    logic [NUM_REGS-1:0] w_rdest_onehot;
    logic [NUM_REGS-1:0] w_ext_onehot;

    // Field decode of the held instruction word.
    assign w_rtype        = (r_instr_q[15:12] == 4'h0);
    assign w_nop          = (r_instr_q == 16'h0000);
    assign w_alu_op       = w_rtype ? r_instr_q[7:4] : r_instr_q[15:12];
    assign w_rsrc         = w_rtype ? r_instr_q[3:0] : 4'h0;
    assign w_rdest        = r_instr_q[11:8];
    assign w_imm_ext      = {{(DATA_W-8){r_instr_q[7]}}, r_instr_q[7:0]};
    assign w_no_wb        = w_nop || (w_alu_op == CMP_OP);
    assign w_rdest_onehot = NUM_REGS'(1) << w_rdest;
    assign w_ext_onehot   = NUM_REGS'(1) << r_ext_addr_q;

    // State register plus capture of the accepted instruction / load address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_instr_q    <= '0;
            r_ext_addr_q <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                if (ext_valid) begin
                    r_ext_addr_q <= ext_addr;
                end else if (instr_valid) begin
                    r_instr_q <= instr;
                end
            end
        end
    end

`ifdef PSR_FLAGS_EN
    logic [4:0] r_psr;

    // Status flags: captured from the ALU at the end of EXEC, NOP excluded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_psr <= '0;
        end else if ((r_state == S_EXEC) && !w_nop) begin
            r_psr <= flags_in;
        end
    end

    assign psr = reset ? 5'b0 : r_psr;
`else
    logic w_flags_unused;
    assign w_flags_unused = ^flags_in;
    assign psr            = '0;
`endif

    // Next-state and control outputs; everything is forced low during reset.
    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        ext_ready   = 1'b0;
        raddrA      = '0;
        raddrB      = '0;
        reg_en      = '0;
        wb_sel      = 2'b00;
        imm_sel     = 2'b00;
        imm         = '0;
        alu_op      = '0;
        busy        = 1'b0;
        done        = 1'b0;

        if (!reset) begin
            busy = (r_state != S_IDLE);

            if ((r_state == S_DECODE) || (r_state == S_EXEC) || (r_state == S_WRITEBACK)) begin
                raddrA  = w_rdest;
                raddrB  = w_rsrc;
                alu_op  = w_alu_op;
                imm_sel = w_rtype ? 2'b01 : 2'b10;
                imm     = w_rtype ? '0 : w_imm_ext;
            end

            case (r_state)
                S_IDLE: begin
                    ext_ready   = ext_valid;
                    instr_ready = ~ext_valid;
                    if (ext_valid) begin
                        w_next = S_LOAD;
                    end else if (instr_valid) begin
                        w_next = S_DECODE;
                    end
                end
                S_LOAD: begin
                    wb_sel = 2'b01;
                    reg_en = w_ext_onehot;
                    w_next = S_IDLE;
                end
                S_DECODE: begin
                    w_next = S_EXEC;
                end
                S_EXEC: begin
                    w_next = S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    done = 1'b1;
                    if (!w_no_wb) begin
                        wb_sel = 2'b10;
                        reg_en = w_rdest_onehot;
                    end
                    w_next = S_IDLE;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// Self-checking bench for datapath_ctrl_fsm: directed scenarios plus a random
// mix of instructions and external loads, checked against a behavioural model.
module tb_datapath_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        ext_valid;
    logic [3:0]  ext_addr;
    logic        ext_ready;
    logic [3:0]  raddrA;
    logic [3:0]  raddrB;
    logic [15:0] reg_en;
    logic [1:0]  wb_sel;
    logic [1:0]  imm_sel;
    logic [15:0] imm;
    logic [3:0]  alu_op;
    logic [4:0]  flags_in;
    logic [4:0]  psr;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [4:0] m_psr = '0;

    datapath_ctrl_fsm #(.DATA_W(16), .NUM_REGS(16), .CMP_OP(4'b1011)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .ext_valid(ext_valid), .ext_addr(ext_addr),
        .ext_ready(ext_ready), .raddrA(raddrA), .raddrB(raddrB), .reg_en(reg_en),
        .wb_sel(wb_sel), .imm_sel(imm_sel), .imm(imm), .alu_op(alu_op),
        .flags_in(flags_in), .psr(psr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // {raddrA,raddrB,alu_op,imm_sel,imm,reg_en,wb_sel,done,busy,instr_ready,ext_ready}
    function automatic logic [51:0] ctrl_vec();
        return {raddrA, raddrB, alu_op, imm_sel, imm, reg_en, wb_sel, done, busy,
                instr_ready, ext_ready};
    endfunction

    // One full instruction: accept, DECODE, EXEC, WRITEBACK, back in IDLE.
    // Called with the DUT in IDLE, #1 after a rising edge.
    task automatic run_instr(input logic [15:0] ins, input logic [4:0] fl, input string tag);
        logic        rtype;
        logic [3:0]  op;
        logic [3:0]  rb;
        logic [15:0] ximm;
        logic [1:0]  xsel;
        logic        writes;
        logic [15:0] xen;
        logic [51:0] dec_exp;
        logic [51:0] wb_exp;
        logic [51:0] act;
        logic [7:0]  lo;

        rtype  = (ins[15:12] == 4'd0);
        op     = rtype ? ins[7:4] : ins[15:12];
        rb     = rtype ? ins[3:0] : 4'd0;
        lo     = ins[7:0];
        ximm   = rtype ? 16'd0 : 16'($signed(lo));
        xsel   = rtype ? 2'b01 : 2'b10;
        writes = !(op == 4'hB || ins == 16'h0000);
        xen    = writes ? (16'd1 << ins[11:8]) : 16'd0;
        dec_exp = {ins[11:8], rb, op, xsel, ximm, 16'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
        wb_exp  = {ins[11:8], rb, op, xsel, ximm, xen, writes ? 2'b10 : 2'b00,
                   1'b1, 1'b1, 1'b0, 1'b0};

        ext_valid = 1'b0; instr_valid = 1'b1; instr = ins; flags_in = fl;
        #1;
        checks++;
        if ({instr_ready, ext_ready, busy} !== 3'b100) begin
            errors++;
            $display("FAIL %s accept: rdy/ext/busy=%b expected 100", tag, {instr_ready, ext_ready, busy});
        end
        @(posedge clk); #1;
        instr_valid = 1'b0; instr = 16'($urandom);
        #1;
        act = ctrl_vec();
        checks++;
        if (act !== dec_exp) begin
            errors++;
            $display("FAIL %s decode: got %h expected %h", tag, act, dec_exp);
        end
        @(posedge clk); #1;
        act = ctrl_vec();
        checks++;
        if (act !== dec_exp || psr !== m_psr) begin
            errors++;
            $display("FAIL %s exec: got %h psr %b expected %h psr %b", tag, act, psr, dec_exp, m_psr);
        end
`ifdef PSR_FLAGS_EN
        if (ins != 16'h0000) m_psr = fl;
`else
        m_psr = '0;
`endif
        @(posedge clk); #1;
        act = ctrl_vec();
        checks++;
        if (act !== wb_exp || psr !== m_psr) begin
            errors++;
            $display("FAIL %s writeback: got %h psr %b expected %h psr %b", tag, act, psr, wb_exp, m_psr);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, busy, reg_en, instr_ready} !== 19'b0000000000000000001 || psr !== m_psr) begin
            errors++;
            $display("FAIL %s next_idle: done/busy/reg_en/rdy=%b psr %b expected done0 busy0 en0 rdy1 psr %b",
                     tag, {done, busy, reg_en, instr_ready}, psr, m_psr);
        end
    endtask

    // External load: one IDLE accept cycle, one LOAD cycle, then IDLE.
    task automatic run_load(input logic [3:0] a, input logic iv, input string tag);
        logic [51:0] act;
        logic [51:0] exp_v;
        ext_valid = 1'b1; ext_addr = a; instr_valid = iv; instr = 16'h0251;
        #1;
        checks++;
        if ({ext_ready, instr_ready, busy} !== 3'b100) begin
            errors++;
            $display("FAIL %s ext_accept: ext/rdy/busy=%b expected 100", tag, {ext_ready, instr_ready, busy});
        end
        @(posedge clk); #1;
        ext_valid = 1'b0; ext_addr = 4'($urandom);
        #1;
        act   = ctrl_vec();
        exp_v = {4'd0, 4'd0, 4'd0, 2'b00, 16'd0, 16'd1 << a, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s load: got %h expected %h", tag, act, exp_v);
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, reg_en, done} !== 18'd0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s post_load: busy/reg_en/done=%b rdy=%b expected zeros rdy 1",
                     tag, {busy, reg_en, done}, instr_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b1; instr = 16'h0251; ext_valid = 1'b1;
        ext_addr = 4'd3; flags_in = 5'b11111;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (ctrl_vec() !== 52'd0 || psr !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h psr %b expected all zero", ctrl_vec(), psr);
        end
        reset = 1'b0; instr_valid = 1'b0; ext_valid = 1'b0;
        #1;
        checks++;
        if ({instr_ready, ext_ready, busy, done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_idle: rdy/ext/busy/done=%b expected 1000",
                     {instr_ready, ext_ready, busy, done});
        end
        m_psr = '0;
    endtask

    task automatic test_rtype();
        run_instr(16'h0251, 5'b00000, "rtype_add");
    endtask

    task automatic test_itype();
        run_instr(16'h53FF, 5'b10001, "itype_imm");
        run_instr(16'hA47F, 5'b00110, "itype_posimm");
    endtask

    task automatic test_cmp();
        run_instr(16'h02B1, 5'b01010, "cmp");
        checks++;
`ifdef PSR_FLAGS_EN
        if (psr !== 5'b01010) begin
            errors++;
            $display("FAIL cmp_psr: got %b expected 01010", psr);
        end
`else
        if (psr !== 5'b00000) begin
            errors++;
            $display("FAIL cmp_psr: got %b expected 00000", psr);
        end
`endif
    endtask

    task automatic test_ext_priority();
        run_load(4'd7, 1'b1, "ext_prio");
        run_instr(16'h0251, 5'b00011, "after_load");
    endtask

    task automatic test_reset_mid();
        run_instr(16'h02B1, 5'b10101, "pre_abort_cmp");
        instr_valid = 1'b1; instr = 16'h0251; flags_in = 5'b11111;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (ctrl_vec() !== 52'd0 || psr !== 5'd0) begin
            errors++;
            $display("FAIL abort_in_reset: got %h psr %b expected all zero", ctrl_vec(), psr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_psr = '0;
        #1;
        checks++;
        if ({busy, done, reg_en, instr_ready} !== 19'b1 || psr !== 5'd0) begin
            errors++;
            $display("FAIL abort_idle: busy/done/reg_en/rdy=%b psr %b expected 0..01 psr 0",
                     {busy, done, reg_en, instr_ready}, psr);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({done, reg_en, busy} !== 18'd0) begin
                errors++;
                $display("FAIL abort_quiet: cycle %0d done/reg_en/busy=%b expected 0", c, {done, reg_en, busy});
            end
        end
    endtask

    task automatic test_nop();
        run_instr(16'h0234, 5'b01100, "set_psr");
        run_instr(16'h0000, 5'b10011, "nop");
    endtask

    task automatic test_back_to_back();
        logic [15:0] ins;
        int unsigned r;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                run_load(4'($urandom), 1'($urandom), "rand_load");
            end else begin
                case (r)
                    2: ins = 16'h0000;
                    3: ins = {4'h0, 4'($urandom), 4'hB, 4'($urandom)};
                    4: ins = {4'hB, 12'($urandom)};
                    5: ins = {4'h0, 12'($urandom)};
                    default: ins = 16'($urandom);
                endcase
                run_instr(ins, 5'($urandom), "rand_instr");
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_cmp();
        test_ext_priority();
        test_reset_mid();
        test_nop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl_fsm.md
Name: datapath_ctrl_fsm

Overview:
Multi-cycle controller that sequences the regfile/ALU datapath for CR16A-style instructions. It accepts one instruction at a time over a valid/ready handshake, decodes R-type and I-type formats, and drives the following datapath controls: regfile read addresses, one-hot write enable, ALU opcode, immediate/operand select and writeback source select. It also arbitrates the single regfile write port between instruction writeback and direct external data loads (inData path), and holds the processor status flags.

Parameters:
DATA_W, 16, datapath width; imm is sign-extended to this width
NUM_REGS, 16, number of registers; width of reg_en
CMP_OP, 4'b1011, opcode that updates flags but never writes back

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
instr_valid  in  1  instr holds a new instruction
instr  in  16  CR16A instruction word
instr_ready  out  1  controller can accept instr this cycle
ext_valid  in  1  request to write external inData into the regfile
ext_addr  in  4  destination register for the external load
ext_ready  out  1  external load accepted this cycle
raddrA  out  4  regfile port A address (Rdest)
raddrB  out  4  regfile port B address (Rsrc)
reg_en  out  NUM_REGS  one-hot regfile write enable
wb_sel  out  2  01 = inData, 10 = ALU out, 00 = none
imm_sel  out  2  01 = rdataB to ALU B, 10 = imm to ALU B, 00 = zero
imm  out  DATA_W  sign-extended instr[7:0]
alu_op  out  4  ALU opcode
flags_in  in  5  ALU flags {C,L,F,Z,N}
psr  out  5  registered status flags
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when an instruction retires

Behaviour:
- States: IDLE, LOAD, DECODE, EXEC, WRITEBACK. Reset (sync) -> IDLE. instr_q = 0, psr = 0.
- All control outputs are combinational from state and instr_q. Every output is 0 while reset is high.
- IDLE:
  - ext_ready = ext_valid. instr_ready = ~ext_valid.
  - If ext_valid: go to LOAD and latch ext_addr. External load has strict priority over instructions.
  - Else if instr_valid: latch instr into instr_q and go to DECODE.
  - Else stay in IDLE.
- LOAD (1 cycle): wb_sel = 01, reg_en = one-hot(ext_addr_q). Then go to IDLE. done is not pulsed.
- Decode rules, applied to instr_q:
  - rdest = [11:8].
  - If [15:12] == 0 (R-type): alu_op = [7:4], raddrB = [3:0], imm_sel = 01.
  - Else (I-type): alu_op = [15:12], raddrB = 0, imm_sel = 10, imm = {{8{[7]}},[7:0]}.
  - raddrA = rdest in DECODE, EXEC and WRITEBACK.
- DECODE (1 cycle): raddrA/raddrB/imm/imm_sel/alu_op driven. reg_en = 0.
- EXEC (1 cycle): same controls held. psr captures flags_in at the clock edge ending EXEC (see optional feature).
- WRITEBACK (1 cycle): controls held, wb_sel = 10, reg_en = one-hot(rdest), done = 1. Then go to IDLE.
  - Exception: if alu_op == CMP_OP, or instr_q == 16'h0000 (NOP), then reg_en = 0 and wb_sel = 00, but done still = 1.
- NOP does not update psr.
- Latency: accept at edge 0; reg_en and done high in cycle 3. Next accept is possible in cycle 4 (4 cycles/instruction). An external load takes 2 cycles.
- instr_ready = 0 and ext_ready = 0 in every state other than IDLE. Requests are held off by the requester, not dropped by this block.
- Reset mid-operation: the next cycle is IDLE with no reg_en, no done, and psr = 0. The aborted instruction is discarded.
- Outputs never show X: unused fields drive 0.

Optional Feature:
PSR_FLAGS_EN:
- Defined: psr is loaded from flags_in at the end of EXEC for every non-NOP instruction, including CMP. psr holds in all other states.
- Undefined: psr is tied to 0 and flags_in is ignored. CMP then retires as a pure no-writeback instruction.

Test Plan:
1. Reset, then instr 16'h0251 (R-type ADD R2,R1) -> DECODE: raddrA=2, raddrB=1, alu_op=5, imm_sel=01. Cycle 3: wb_sel=10, reg_en=16'h0004, done=1. Cycle 4: instr_ready=1.
2. instr 16'h53FF (I-type, opcode 5, R3, imm 0xFF) -> imm=16'hFFFF, imm_sel=10, alu_op=5, reg_en=16'h0008 in WRITEBACK.
3. instr 16'h02B1 (CMP) with flags_in=5'b01010 during EXEC -> reg_en stays 0 throughout, done=1 in cycle 3. psr=5'b01010 with PSR_FLAGS_EN, 0 without.
4. ext_valid=1 with ext_addr=7 and instr_valid=1 in the same IDLE cycle -> ext_ready=1, instr_ready=0. Next cycle: wb_sel=01, reg_en=16'h0080. Following cycle: the instruction is accepted.
5. reset asserted during EXEC of 16'h0251 -> next cycle IDLE, reg_en never asserted, done never pulses, psr=0.
6. instr 16'h0000 -> 4-cycle sequence, done=1 in cycle 3, reg_en=0, psr unchanged.
